// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, one operation in flight, registered ALU operands,
// captured result/zero returned on a per-requester response channel.
module alu_arbiter #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_zero,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_zero,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state_reg, state_next;
   logic             last_grant_reg;
   logic             grant_reg;
   logic [WIDTH-1:0] a_reg, b_reg, res_reg;
   logic [OPW-1:0]   op_reg;
   logic             zero_reg;

   logic             sel;        // requester that would win in IDLE
   logic             accept;     // handshake happens this cycle
   logic             resp_done;  // response consumed this cycle

   // Grant choice: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      sel = req1_valid;
      if (req0_valid && req1_valid) begin
         sel = ~last_grant_reg;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs; ready is gated by reset so nothing is accepted while held.
   always_comb begin
      state_next  = state_reg;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      accept      = 1'b0;
      resp_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rst_n && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = ~sel;
               req1_ready = sel;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = RESP;
         end
         RESP: begin
            resp0_valid = ~grant_reg;
            resp1_valid = grant_reg;
            resp_done   = grant_reg ? resp1_ready : resp0_ready;
            if (resp_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latch on handshake, result capture in ISSUE, round-robin pointer update on completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg <= 1'b1;
         grant_reg      <= 1'b0;
         a_reg          <= '0;
         b_reg          <= '0;
         op_reg         <= '0;
         res_reg        <= '0;
         zero_reg       <= 1'b0;
      end else begin
         if (accept) begin
            grant_reg <= sel;
            a_reg     <= sel ? req1_a  : req0_a;
            b_reg     <= sel ? req1_b  : req0_b;
            op_reg    <= sel ? req1_op : req0_op;
         end
         if (state_reg == ISSUE) begin
            res_reg  <= alu_result;
            zero_reg <= alu_zero;
         end
         if (resp_done) begin
            last_grant_reg <= grant_reg;
         end
      end
   end

   assign alu_data1    = a_reg;
   assign alu_data2    = b_reg;
   assign alu_op       = op_reg;
   assign resp0_result = res_reg;
   assign resp1_result = res_reg;
   assign resp0_zero   = zero_reg;
   assign resp1_zero   = zero_reg;
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU stub.
module tb_alu_arbiter;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0][7:0] req_a;
   logic [1:0][7:0] req_b;
   logic [1:0][2:0] req_op;
   logic [1:0]      resp_valid;
   logic [1:0]      resp_ready;
   logic [1:0][7:0] resp_result;
   logic [1:0]      resp_zero;
   logic [7:0]      alu_data1, alu_data2, alu_result;
   logic [2:0]      alu_op;
   logic            alu_zero;
   logic            busy;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.WIDTH(8), .OPW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
      .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
      .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
      .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
      .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]),
      .resp0_result(resp_result[0]), .resp0_zero(resp_zero[0]),
      .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]),
      .resp1_result(resp_result[1]), .resp1_zero(resp_zero[1]),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: op 0 add, op 1 subtract, zero flag from the result.
   always_comb begin
      case (alu_op)
         3'd0:    alu_result = alu_data1 + alu_data2;
         3'd1:    alu_result = alu_data1 - alu_data2;
         default: alu_result = 8'h00;
      endcase
      alu_zero = (alu_result == 8'h00);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One uncontended operation from requester who, with every stage checked at its exact cycle.
   task automatic do_op(input int who, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] res, input logic z);
      req_valid       = '0;
      req_valid[who]  = 1'b1;
      req_a[who]      = a;
      req_b[who]      = b;
      req_op[who]     = op;
      resp_ready      = '0;
      #1;
      chk($sformatf("op%0d_ready", who), {30'd0, req_ready}, 32'(1 << who));
      $display("op req%0d a=%02h b=%02h op=%0d accepted", who, a, b, op);
      tick();
      req_valid  = '0;
      req_a[who] = 8'hAA;   // payload must have been sampled at the handshake only
      req_b[who] = 8'h55;
      #1;
      chk("issue_d1", alu_data1, a);
      chk("issue_d2", alu_data2, b);
      chk("issue_op", alu_op, op);
      chk("issue_busy", busy, 1);
      chk("issue_rv", resp_valid, 0);
      tick();
      chk($sformatf("resp%0d_valid", who), {30'd0, resp_valid}, 32'(1 << who));
      chk("resp_result", resp_result[who], res);
      chk("resp_zero", resp_zero[who], z);
      $display("op req%0d result=%02h zero=%0d", who, resp_result[who], resp_zero[who]);
      resp_ready[who] = 1'b1;
      tick();
      resp_ready = '0;
      #1;
      chk("done_busy", busy, 0);
      chk("done_rv", resp_valid, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      resp_ready = 2'b00;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      req_a[0] = 8'h12; req_b[0] = 8'h34;
      req_a[1] = 8'h56; req_b[1] = 8'h78;

      // Reset held two cycles with both requesters valid.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ready", req_ready, 0);
         chk("rst_rv", resp_valid, 0);
         chk("rst_d1", alu_data1, 0);
         chk("rst_d2", alu_data2, 0);
         chk("rst_op", alu_op, 0);
         chk("rst_busy", busy, 0);
         chk("rst_res", resp_result[0], 0);
         $display("reset cycle %0d checked", i);
      end
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Single request, then zero/wrap and subtract-to-zero on requester 1.
      do_op(0, 8'h01, 8'hFE, 3'd0, 8'hFF, 1'b0);
      do_op(1, 8'h80, 8'h80, 3'd0, 8'h00, 1'b1);
      do_op(1, 8'h05, 8'h05, 3'd1, 8'h00, 1'b1);

      // Contention: last served was 1, so grants go 0,1,0,1 every 3 cycles.
      req_a[0] = 8'h10; req_b[0] = 8'h20; req_op[0] = 3'd0;
      req_a[1] = 8'h50; req_b[1] = 8'h30; req_op[1] = 3'd1;
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int g;
         g = i % 2;
         #1;
         chk($sformatf("cont%0d_ready", i), {30'd0, req_ready}, 32'(1 << g));
         tick();
         chk($sformatf("cont%0d_issue_ready", i), req_ready, 0);
         chk($sformatf("cont%0d_d1", i), alu_data1, (g == 0) ? 8'h10 : 8'h50);
         chk($sformatf("cont%0d_rv_early", i), resp_valid, 0);
         tick();
         chk($sformatf("cont%0d_rv", i), {30'd0, resp_valid}, 32'(1 << g));
         chk($sformatf("cont%0d_res", i), resp_result[g], (g == 0) ? 8'h30 : 8'h20);
         $display("contention op %0d grant=%0d result=%02h", i, g, resp_result[g]);
         tick();
      end
      chk("cont_end_busy", busy, 0);

      // Backpressure: resp0_ready low for 5 cycles while both requesters keep asking.
      resp_ready = 2'b00;
      req_valid  = 2'b01;
      req_a[0] = 8'h0F; req_b[0] = 8'h01; req_op[0] = 3'd1;
      #1;
      chk("bp_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b11;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_rv", i), resp_valid, 2'b01);
         chk($sformatf("bp%0d_res", i), resp_result[0], 8'h0E);
         chk($sformatf("bp%0d_ready", i), req_ready, 0);
         chk($sformatf("bp%0d_busy", i), busy, 1);
         $display("backpressure cycle %0d result=%02h", i, resp_result[0]);
         tick();
      end
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      #1;
      chk("bp_rel_busy", busy, 0);
      chk("bp_rel_ready", req_ready, 2'b10);   // last served 0, so 1 wins the tie
      req_valid = 2'b00;
      #1;
      chk("bp_drop_ready", req_ready, 0);
      tick();
      chk("bp_drop_busy", busy, 0);

      // Reset during ISSUE discards the operation.
      req_valid = 2'b01;
      req_a[0] = 8'h33; req_b[0] = 8'h11; req_op[0] = 3'd0;
      tick();
      req_valid = 2'b00;
      chk("mid_issue_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_busy", busy, 0);
      chk("mid_rv", resp_valid, 0);
      chk("mid_d1", alu_data1, 0);
      $display("mid-op reset applied");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid_quiet%0d", i), resp_valid, 0);
      end

      // After reset, a tie goes to requester 0; then normal operation resumes.
      req_valid = 2'b11;
      #1;
      chk("post_tie_ready", req_ready, 2'b01);
      req_valid = 2'b00;
      #1;
      do_op(1, 8'h40, 8'h01, 3'd1, 8'h3F, 1'b0);
      do_op(0, 8'h22, 8'h22, 3'd1, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit combinational ALU between two requesters, e.g. the fetch unit (PC increment) and the execute unit. Each requester uses a valid/ready handshake to submit an operand pair and op code. The block drives the ALU operand and op inputs from registers, captures `result` and `zero`, and returns them on a per-requester response channel. Arbitration is round-robin, with one operation in flight at a time.

## Interface
- `WIDTH`, 8, data width of operands and result; must match the ALU
- `OPW`, 3, op-code width forwarded to the ALU
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req0_valid` in 1: requester 0 has an operation
- `req0_ready` out 1: requester 0 operation accepted this cycle
- `req0_a` in WIDTH: operand A for requester 0
- `req0_b` in WIDTH: operand B for requester 0
- `req0_op` in OPW: op code for requester 0
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1
- `resp0_valid` out 1: result available for requester 0
- `resp0_ready` in 1: requester 0 takes the result
- `resp0_result` out WIDTH: captured ALU result
- `resp0_zero` out 1: captured ALU zero flag
- `resp1_valid`, `resp1_ready`, `resp1_result`, `resp1_zero`: same as requester 0, for requester 1
- `alu_data1` out WIDTH: to ALU `data1`
- `alu_data2` out WIDTH: to ALU `data2`
- `alu_op` out OPW: to ALU op select
- `alu_result` in WIDTH: from ALU `result`
- `alu_zero` in 1: from ALU `zero`
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant selection: if exactly one `reqN_valid` is high, grant that requester. If both are high, grant the requester not equal to `last_grant`.
  - Ready: `reqN_ready` is asserted combinationally for the granted requester only, in this cycle only.
  - On the handshake, latch a/b/op into the operand registers, record `grant`, and go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - `alu_data1`/`alu_data2`/`alu_op` are driven from the operand registers. They are held stable in all states and only change on an accepted handshake.
  - At the end of the cycle, capture `alu_result` into `res_q` and `alu_zero` into `zero_q`, then go to RESP.
- RESP:
  - `resp[grant]_valid` is high; the other response valid is low.
  - On `resp[grant]_ready`, set `last_grant <= grant` and go to IDLE.
  - While waiting, stay in RESP; no request is accepted and both `reqN_ready` are low.
- Both `respN_result` and `respN_zero` outputs show `res_q`/`zero_q`. Only the `valid` signals are steered by `grant`.
- `zero` is taken from the ALU and never recomputed locally.
- Requesters must hold valid and payload until ready. The arbiter samples the payload only on the handshake cycle.

## Timing
- Reset values (`rst_n` low at a rising edge):
  - state=IDLE, `last_grant`=1 (requester 0 wins the first tie), `grant`=0
  - operand registers=0, so `alu_data1`=`alu_data2`=0 and `alu_op`=0
  - `res_q`=0, `zero_q`=0, all `respN_valid`=0, `busy`=0
  - `reqN_ready`=0 while `rst_n` is low
- Latency: request accepted in cycle N → ALU operands valid in cycle N+1 → `resp_valid` high in cycle N+2.
- Response consumed in cycle M → IDLE in M+1, where the next request can be accepted. Minimum initiation interval is 3 cycles.
- Reset asserted mid-operation (ISSUE or RESP): back to IDLE after that edge. The in-flight result is discarded, `resp_valid` is low in the next cycle, and no response is ever delivered for it.
- `resp_ready` already high when `resp_valid` rises: completes in that same cycle.
- A requester whose `valid` drops in IDLE before being granted is not served. No state is kept for it.
- Back-to-back contention: both requesters continuously valid → grants alternate 0,1,0,1. With `last_grant`=1 after reset, the first grant goes to requester 0.

## Test plan
Bench uses a behavioural ALU stub: op 0 → a+b (mod 256), op 1 → a−b, `zero` = (result==0).
- Reset: hold `rst_n` low 2 cycles with both requests valid → all `ready`/`resp_valid` 0, `alu_data1`=`alu_data2`=0x00, `busy`=0.
- Single request: req0 a=0x01 b=0xFE op0 accepted in cycle N → `alu_data1`=0x01 and `alu_data2`=0xFE in N+1; `resp0_valid` in N+2 with result=0xFF, zero=0; `resp1_valid` stays 0.
- Zero and wrap: req1 a=0x80 b=0x80 op0 → `resp1_result`=0x00, `resp1_zero`=1. Then req1 a=0x05 b=0x05 op1 → result 0x00, zero=1.
- Contention: both valid continuously, `resp_ready` tied high, for 4 operations → grants 0,1,0,1; each response arrives exactly 2 cycles after its accept; requests spaced 3 cycles apart.
- Backpressure: `resp0_ready` held low 5 cycles → `resp0_valid` and `resp0_result` stable, both `reqN_ready` 0, `busy`=1. Release → IDLE next cycle.
- Mid-op reset: assert `rst_n` low during ISSUE → IDLE the following cycle, no `resp_valid` for that op. The next request completes normally with the correct result.
